// File: rtl/fir_pkg.sv
// fir_pkg: shared FSM states, width helpers and output saturation for the symmetric FIR
package fir_pkg;
   typedef enum logic [2:0] {CLEAR, IDLE, PRIME, ACC, SCALE} state_t;
   function automatic int ka_w(input int ord);
      return (ord / 2 + 1) > 1 ? $clog2(ord / 2 + 1) : 1;
   endfunction
   function automatic int acc_w(input int s, input int c, input int ka);
      return s + 1 + c + ka;
   endfunction
   function automatic logic signed [127:0] sat(input logic signed [127:0] v, input int s);
      logic signed [127:0] hi, lo;
      hi = (128'sd1 <<< (s - 1)) - 128'sd1;
      lo = -hi - 128'sd1;
      return (v > hi) ? hi : (v < lo) ? lo : v;
   endfunction
endpackage

// File: rtl/fir_hist_ram.sv
// fir_hist_ram: circular sample history with clear sweep and the two symmetric pre-add reads
module fir_hist_ram #(
   parameter int ORD = 64,
   parameter int S   = 16,
   parameter int KA  = 6
)(
   input  logic                clk,
   input  logic                rst,
   input  logic                i_clr,
   input  logic                i_we,
   input  logic signed [S-1:0] i_din,
   input  logic [KA-1:0]       i_k,
   output logic signed [S-1:0] o_a,
   output logic signed [S-1:0] o_b,
   output logic                o_clr_done
);
   localparam int L  = ORD + 1;
   localparam int AW = $clog2(L) > 0 ? $clog2(L) : 1;
   logic signed [S-1:0] r_mem [L];
   logic signed [S-1:0] r_a, r_b;
   logic [AW-1:0]       r_wptr, r_cptr, w_ra, w_rb;
   logic [AW+1:0]       w_sa, w_sb;
   assign o_a        = r_a;
   assign o_b        = r_b;
   assign o_clr_done = r_cptr == AW'(ORD);
   // newest sample sits at wptr-1, so x[n-k] is wptr-1-k and x[n-ORD+k] is wptr+k (mod ORD+1)
   always_comb begin
      w_sa = (AW+2)'(r_wptr) + (AW+2)'(ORD) - (AW+2)'(i_k);
      w_sb = (AW+2)'(r_wptr) + (AW+2)'(i_k);
      w_ra = AW'(w_sa >= (AW+2)'(L) ? w_sa - (AW+2)'(L) : w_sa);
      w_rb = AW'(w_sb >= (AW+2)'(L) ? w_sb - (AW+2)'(L) : w_sb);
   end
   // write pointer wraps ORD->0; clear pointer sweeps every entry once while clearing
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr <= '0;
         r_cptr <= '0;
      end else begin
         r_cptr <= (i_clr && !o_clr_done) ? r_cptr + 1'b1 : '0;
         if (i_we && !i_clr) r_wptr <= (r_wptr == AW'(ORD)) ? '0 : r_wptr + 1'b1;
      end
   end
   // single write port (clear zeroes or new sample), two registered reads
   always_ff @(posedge clk) begin
      if (!rst && (i_clr || i_we)) r_mem[i_clr ? r_cptr : r_wptr] <= i_clr ? '0 : i_din;
      r_a <= r_mem[w_ra];
      r_b <= r_mem[w_rb];
   end
endmodule

// File: rtl/fir_sym_stream.sv
// fir_sym_stream: streaming odd-length symmetric FIR with one shared pre-add/MAC datapath
module fir_sym_stream import fir_pkg::*; #(
   parameter  int ORD   = 64,
   parameter  int S     = 16,
   parameter  int C     = 16,
   parameter  int SHIFT = C - 1,
   localparam int KA    = ka_w(ORD)
)(
   input  logic                clk,
   input  logic                rst,
   input  logic signed [S-1:0] din,
   input  logic                din_valid,
   output logic                din_ready,
   output logic signed [S-1:0] dout,
   output logic                dout_valid,
   input  logic                bypass,
   input  logic                c_we,
   input  logic [KA-1:0]       c_addr,
   input  logic signed [C-1:0] c_in,
   output logic                c_ready,
   output logic                coef_valid
);
   localparam int K   = ORD / 2 + 1;
   localparam int P   = S + 1 + C;
   localparam int AW  = acc_w(S, C, KA);
   localparam int RSH = SHIFT > 0 ? SHIFT - 1 : 0;
   localparam logic signed [AW:0] RND = SHIFT > 0 ? (AW+1)'(1) << RSH : '0;
   state_t              r_state, w_next;
   logic [KA-1:0]       r_k, w_rd_k;
   logic signed [AW-1:0] r_acc;
   logic signed [C-1:0] r_coef [K];
   logic signed [C-1:0] r_h;
   logic [K-1:0]        r_map, w_map_nxt;
   logic                r_cv, r_dv, w_accept, w_cwr, w_last, w_clr_done;
   logic signed [S-1:0] r_dout, w_a, w_b;
   logic signed [S:0]   w_pre;
   logic signed [P-1:0] w_prod;
   logic signed [AW:0]  w_rnd;
   assign dout       = r_dout;
   assign dout_valid = r_dv;
   assign coef_valid = r_cv;
   assign w_accept   = din_valid && din_ready;
   assign w_cwr      = c_we && c_ready && !rst && ({1'b0, c_addr} < (KA+1)'(K));
   assign w_last     = r_k == KA'(K - 1);
   assign w_map_nxt  = r_map | (w_cwr ? K'(1) << c_addr : '0);
   assign w_pre      = w_last ? (S+1)'(w_a) : (S+1)'(w_a) + (S+1)'(w_b);
   assign w_prod     = P'(w_pre) * P'(r_h);
   assign w_rnd      = (AW+1)'(r_acc) + RND;
   fir_hist_ram #(.ORD(ORD), .S(S), .KA(KA)) u_hist (
      .clk(clk), .rst(rst), .i_clr(r_state == CLEAR), .i_we(w_accept), .i_din(din),
      .i_k(w_rd_k), .o_a(w_a), .o_b(w_b), .o_clr_done(w_clr_done)
   );
   // state register; reset abandons any computation and restarts the history clear
   always_ff @(posedge clk) r_state <= rst ? CLEAR : w_next;
   // next-state: clear sweep, idle, then prime/accumulate/scale for filtered samples
   always_comb begin
      w_next = r_state;
      case (r_state)
         CLEAR:   w_next = w_clr_done ? IDLE : CLEAR;
         IDLE:    w_next = (w_accept && !bypass) ? PRIME : IDLE;
         PRIME:   w_next = ACC;
         ACC:     w_next = w_last ? SCALE : ACC;
         default: w_next = IDLE;
      endcase
   end
   // handshake outputs and the read index issued one cycle ahead of its use
   always_comb begin
      din_ready = (r_state == IDLE) && r_cv;
      c_ready   = (r_state == CLEAR) || (r_state == IDLE);
      w_rd_k    = (r_state == ACC && !w_last) ? r_k + 1'b1 : '0;
   end
   // tap counter, accumulator, rounded/saturated or bypassed output register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_k    <= '0;
         r_acc  <= '0;
         r_dout <= '0;
         r_dv   <= 1'b0;
      end else begin
         r_k   <= (r_state == ACC) ? r_k + 1'b1 : '0;
         r_acc <= (r_state == PRIME) ? '0 : (r_state == ACC) ? r_acc + AW'(w_prod) : r_acc;
         r_dv  <= (r_state == SCALE) || (w_accept && bypass);
         if (r_state == SCALE) r_dout <= S'(sat(128'(w_rnd) >>> SHIFT, S));
         else if (w_accept && bypass) r_dout <= din;
      end
   end
   // coefficient RAM keeps its contents through reset; only the tracking bitmap clears
   always_ff @(posedge clk) begin
      if (w_cwr) r_coef[c_addr] <= c_in;
      r_h <= r_coef[w_rd_k];
   end
   // coefficient tracking: valid once every unique tap has been written since reset
   always_ff @(posedge clk) begin
      if (rst) begin
         r_map <= '0;
         r_cv  <= 1'b0;
      end else begin
         r_map <= w_map_nxt;
         r_cv  <= &w_map_nxt;
      end
   end
endmodule
